// File: rtl/uxn1330_host_bridge_if.sv
// Host terminal + memory user-port bundle for the UXN1330 host bridge.
// Pure wiring, no latency of its own.
// slave = the bridge; master = FX3 host and memory controller side.
interface uxn1330_host_bridge_if;
    logic        host_cmd_valid;
    logic        host_cmd_ready;
    logic        host_cmd_wr;
    logic [15:0] host_term;
    logic [29:0] host_addr;
    logic [31:0] host_len;
    logic [7:0]  host_wdata;
    logic        host_wvalid;
    logic        host_wready;
    logic [7:0]  host_rdata;
    logic        host_rvalid;
    logic        host_rready;
    logic        host_done;
    logic        pll_locked;
    logic        calib_done;
    logic        mem_cmd_valid;
    logic        mem_cmd_ready;
    logic        mem_cmd_we;
    logic [27:0] mem_cmd_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    modport slave (
        input  host_cmd_valid, host_cmd_wr, host_term, host_addr, host_len,
               host_wdata, host_wvalid, host_rready, pll_locked, calib_done,
               mem_cmd_ready, mem_rdata, mem_rvalid,
        output host_cmd_ready, host_wready, host_rdata, host_rvalid, host_done,
               mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wdata, mem_wmask
    );

    modport master (
        output host_cmd_valid, host_cmd_wr, host_term, host_addr, host_len,
               host_wdata, host_wvalid, host_rready, pll_locked, calib_done,
               mem_cmd_ready, mem_rdata, mem_rvalid,
        input  host_cmd_ready, host_wready, host_rdata, host_rvalid, host_done,
               mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/uxn1330_host_bridge.sv
// Host terminal bridge: register get/set (FPGA, DRAM_CTRL) and DRAM byte streams; makes resetb.
// Latency: register bytes one per two clocks; DRAM reads one word in flight, writes flush per word.
// Backpressure: host_wready drops while a flush is stalled; read bytes held until host_rready.
// Optional DRAM bound check (reads 0, no write, sticky status bit2) via DRAM_RANGE_CHECK_EN.
module uxn1330_host_bridge #(
    parameter logic [15:0] VERSION        = 16'h0130,
    parameter logic [15:0] TERM_FPGA      = 16'h0001,
    parameter logic [15:0] TERM_DRAM_CTRL = 16'h0002,
    parameter logic [15:0] TERM_DRAM      = 16'h0003,
    parameter int          RESET_CYCLES   = 16
`ifdef DRAM_RANGE_CHECK_EN
    ,
    parameter int          DRAM_BYTES     = 2**26
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  resetb,
    uxn1330_host_bridge_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, REG_RD, REG_WR, MEM_WAIT, MEM_RD, MEM_WR, DONE} state_t;

    state_t      state_q;
    logic [15:0] rst_cnt_q;
    logic        wr_q;
    logic [15:0] term_q;
    logic [29:0] addr_q;
    logic [31:0] cnt_q;
    logic [31:0] bidx_q;
    logic [7:0]  rdata_q;
    logic        rvalid_q;
    logic        mvalid_q;
    logic        mwe_q;
    logic [27:0] maddr_q;
    logic [31:0] mwdata_q;
    logic [3:0]  mwmask_q;
    logic [31:0] wbuf_q;
    logic [3:0]  wmask_q;
    logic [31:0] rword_q;
    logic        rword_vld_q;
    logic        rd_pend_q;
    logic        range_err_q;

    logic [1:0]  lane;
    logic        last_byte;
    logic        flush_busy;
    logic        in_range;
    logic [15:0] reg_word;
    logic [7:0]  reg_byte;
    logic [31:0] wbuf_d;
    logic [3:0]  wmask_d;
    logic        wr_fire;

    assign resetb             = (rst_cnt_q == 16'(RESET_CYCLES));
    assign bus.host_cmd_ready = resetb & (state_q == IDLE);
    assign bus.host_wready    = ((state_q == REG_WR) | ((state_q == MEM_WR) & ~flush_busy))
                                & (cnt_q != 32'd0);
    assign bus.host_rdata     = rdata_q;
    assign bus.host_rvalid    = rvalid_q;
    assign bus.host_done      = (state_q == DONE);
    assign bus.mem_cmd_valid  = mvalid_q;
    assign bus.mem_cmd_we     = mwe_q;
    assign bus.mem_cmd_addr   = maddr_q;
    assign bus.mem_wdata      = mwdata_q;
    assign bus.mem_wmask      = mwmask_q;
    assign wr_fire            = bus.host_wvalid & bus.host_wready;

    // Byte lane, register byte selection and write-buffer merge for the current byte.
    always_comb begin
        lane       = addr_q[1:0];
        last_byte  = (cnt_q == 32'd1);
        flush_busy = mvalid_q & ~bus.mem_cmd_ready;
`ifdef DRAM_RANGE_CHECK_EN
        in_range   = ({2'b00, addr_q} < 32'(DRAM_BYTES));
`else
        in_range   = 1'b1;
`endif
        reg_word = 16'h0000;
        if (addr_q == 30'd0) begin
            if (term_q == TERM_FPGA)
                reg_word = VERSION;
            else if (term_q == TERM_DRAM_CTRL)
                reg_word = {13'd0, range_err_q, bus.calib_done, bus.pll_locked};
        end
        reg_byte = (bidx_q == 32'd0) ? reg_word[7:0] :
                   (bidx_q == 32'd1) ? reg_word[15:8] : 8'h00;
        wbuf_d = wbuf_q;
        wbuf_d[{lane, 3'b000} +: 8] = bus.host_wdata;
        wmask_d = wmask_q;
        if (in_range)
            wmask_d[lane] = 1'b1;
    end

    // Power-on style counter: resetb rises RESET_CYCLES clocks after reset drops.
    always_ff @(posedge clk) begin
        if (reset)
            rst_cnt_q <= 16'd0;
        else if (!resetb)
            rst_cnt_q <= rst_cnt_q + 16'd1;
    end

    // Command FSM with all host/memory outputs registered; reset aborts and drops partial words.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            term_q      <= 16'd0;
            addr_q      <= 30'd0;
            cnt_q       <= 32'd0;
            bidx_q      <= 32'd0;
            rdata_q     <= 8'd0;
            rvalid_q    <= 1'b0;
            mvalid_q    <= 1'b0;
            mwe_q       <= 1'b0;
            maddr_q     <= 28'd0;
            mwdata_q    <= 32'd0;
            mwmask_q    <= 4'd0;
            wbuf_q      <= 32'd0;
            wmask_q     <= 4'd0;
            rword_q     <= 32'd0;
            rword_vld_q <= 1'b0;
            rd_pend_q   <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            if (mvalid_q & bus.mem_cmd_ready)
                mvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.host_cmd_valid & bus.host_cmd_ready) begin
                        wr_q        <= bus.host_cmd_wr;
                        term_q      <= bus.host_term;
                        addr_q      <= bus.host_addr;
                        cnt_q       <= bus.host_len;
                        bidx_q      <= 32'd0;
                        wmask_q     <= 4'd0;
                        rword_vld_q <= 1'b0;
                        rd_pend_q   <= 1'b0;
                        if (bus.host_len == 32'd0)
                            state_q <= DONE;
                        else if (bus.host_term == TERM_DRAM)
                            state_q <= MEM_WAIT;
                        else
                            state_q <= bus.host_cmd_wr ? REG_WR : REG_RD;
                    end
                end
                REG_RD: begin
                    if (!rvalid_q) begin
                        rdata_q  <= reg_byte;
                        rvalid_q <= 1'b1;
                        if (term_q == TERM_DRAM_CTRL && addr_q == 30'd0 && bidx_q == 32'd0)
                            range_err_q <= 1'b0;
                    end else if (bus.host_rready) begin
                        rvalid_q <= 1'b0;
                        bidx_q   <= bidx_q + 32'd1;
                        cnt_q    <= cnt_q - 32'd1;
                        if (last_byte)
                            state_q <= DONE;
                    end
                end
                REG_WR: begin
                    if (wr_fire) begin
                        cnt_q <= cnt_q - 32'd1;
                        if (last_byte)
                            state_q <= DONE;
                    end
                end
                MEM_WAIT: begin
                    if (bus.calib_done)
                        state_q <= wr_q ? MEM_WR : MEM_RD;
                end
                MEM_WR: begin
                    if (wr_fire) begin
                        addr_q <= addr_q + 30'd1;
                        cnt_q  <= cnt_q - 32'd1;
                        if (!in_range)
                            range_err_q <= 1'b1;
                        if (lane == 2'd3 || last_byte) begin
                            wmask_q <= 4'd0;
                            if (wmask_d != 4'd0) begin
                                mvalid_q <= 1'b1;
                                mwe_q    <= 1'b1;
                                maddr_q  <= addr_q[29:2];
                                mwdata_q <= wbuf_d;
                                mwmask_q <= wmask_d;
                            end
                        end else begin
                            wbuf_q  <= wbuf_d;
                            wmask_q <= wmask_d;
                        end
                    end else if (cnt_q == 32'd0 && !flush_busy) begin
                        state_q <= DONE;
                    end
                end
                MEM_RD: begin
                    if (mvalid_q & bus.mem_cmd_ready)
                        rd_pend_q <= 1'b1;
                    if (rvalid_q) begin
                        if (bus.host_rready) begin
                            rvalid_q <= 1'b0;
                            addr_q   <= addr_q + 30'd1;
                            cnt_q    <= cnt_q - 32'd1;
                            if (lane == 2'd3)
                                rword_vld_q <= 1'b0;
                            if (last_byte)
                                state_q <= DONE;
                        end
                    end else if (rword_vld_q) begin
                        rdata_q  <= rword_q[{lane, 3'b000} +: 8];
                        rvalid_q <= 1'b1;
                    end else if (rd_pend_q) begin
                        if (bus.mem_rvalid) begin
                            rword_q     <= bus.mem_rdata;
                            rword_vld_q <= 1'b1;
                            rd_pend_q   <= 1'b0;
                        end
                    end else if (!mvalid_q) begin
                        if (in_range) begin
                            mvalid_q <= 1'b1;
                            mwe_q    <= 1'b0;
                            maddr_q  <= addr_q[29:2];
                        end else begin
                            // Out-of-range word: no memory traffic, bytes read as zero.
                            rword_q     <= 32'd0;
                            rword_vld_q <= 1'b1;
                            range_err_q <= 1'b1;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uxn1330_host_bridge.sv
// Bench for uxn1330_host_bridge: directed sequence with random data and random handshakes.
// Host reference: byte-addressed array of what the host has written; DRAM model is word-based.
// Memory accepts commands randomly and answers reads after a random delay.
module tb_uxn1330_host_bridge;
    localparam logic [15:0] TERM_FPGA      = 16'h0001;
    localparam logic [15:0] TERM_DRAM_CTRL = 16'h0002;
    localparam logic [15:0] TERM_DRAM      = 16'h0003;

    logic clk = 1'b0;
    logic reset;
    logic resetb;
    int   errors = 0;
    int   checks = 0;

    uxn1330_host_bridge_if bus();

    uxn1330_host_bridge dut (
        .clk    (clk),
        .reset  (reset),
        .resetb (resetb),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  ref_mem [int unsigned];
    logic [31:0] dram    [int unsigned];
    logic [31:0] rsp_q[$];
    logic [7:0]  wq[$];
    logic [7:0]  rd_q[$];
    int          rsp_dly = 0;
    int          wr_cmds = 0;
    int          all_cmds = 0;
    int          bad_masks = 0;
    logic [27:0] last_addr = '0;
    logic [3:0]  last_mask = '0;
    logic [31:0] mw;

    // Memory controller model: random ready, delayed read responses.
    always @(negedge clk) begin
        bus.mem_cmd_ready = ($urandom_range(0, 3) != 0);
        bus.mem_rvalid    = 1'b0;
        if (rsp_q.size() != 0) begin
            if (rsp_dly == 0) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = rsp_q.pop_front();
                rsp_dly        = $urandom_range(0, 3);
            end else begin
                rsp_dly--;
            end
        end
    end

    always @(posedge clk) begin
        if (bus.mem_cmd_valid && bus.mem_cmd_ready) begin
            all_cmds++;
            mw = dram.exists(bus.mem_cmd_addr) ? dram[bus.mem_cmd_addr] : 32'd0;
            if (bus.mem_cmd_we) begin
                for (int k = 0; k < 4; k++)
                    if (bus.mem_wmask[k]) mw[8*k +: 8] = bus.mem_wdata[8*k +: 8];
                dram[bus.mem_cmd_addr] = mw;
                wr_cmds++;
                if (bus.mem_wmask != 4'hF) bad_masks++;
                last_addr = bus.mem_cmd_addr;
                last_mask = bus.mem_wmask;
            end else begin
                rsp_q.push_back(mw);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed timeout expected DUT response", tag);
    endtask

    task automatic send_cmd(input logic wr, input logic [15:0] term, input logic [29:0] addr,
                            input logic [31:0] len);
        int t;
        t = 0;
        @(negedge clk); #1;
        bus.host_cmd_valid = 1'b1;
        bus.host_cmd_wr    = wr;
        bus.host_term      = term;
        bus.host_addr      = addr;
        bus.host_len       = len;
        while (!bus.host_cmd_ready && t < 3000) begin
            @(negedge clk); #1;
            t++;
        end
        if (!bus.host_cmd_ready) timeout("cmd_accept");
        @(posedge clk); #1;
        bus.host_cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.host_done && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (!bus.host_done) begin
            timeout({tag, "_done"});
        end else begin
            @(negedge clk);
            check({tag, "_done_one_cycle"}, bus.host_done, 1'b0);
        end
    endtask

    task automatic send_wbytes(input int n);
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            bus.host_wdata  = wq[i];
            bus.host_wvalid = 1'b1;
            do begin
                @(negedge clk); #1;
                t++;
            end while (!bus.host_wready && t < 3000);
            if (!bus.host_wready) timeout("wready");
            @(posedge clk); #1;
        end
        bus.host_wvalid = 1'b0;
    endtask

    task automatic host_write(input logic [15:0] term, input logic [29:0] addr, input int len);
        send_cmd(1'b1, term, addr, 32'(len));
        send_wbytes(len);
        if (term == TERM_DRAM)
            for (int i = 0; i < len; i++)
                ref_mem[(32'(addr) + 32'(i)) & 32'h3FFF_FFFF] = wq[i];
        wait_done("write");
    endtask

    task automatic host_read(input logic [15:0] term, input logic [29:0] addr, input int len);
        int t;
        t = 0;
        rd_q.delete();
        send_cmd(1'b0, term, addr, 32'(len));
        while (rd_q.size() < len && t < 40 * len + 2000) begin
            @(negedge clk); #1;
            bus.host_rready = ($urandom_range(0, 3) != 0);
            if (bus.host_rvalid && bus.host_rready) rd_q.push_back(bus.host_rdata);
            t++;
        end
        if (rd_q.size() < len) timeout("read_bytes");
        @(posedge clk); #1;
        bus.host_rready = 1'b0;
        wait_done("read");
    endtask

    task automatic dram_read_check(input string tag, input logic [29:0] addr, input int len);
        int unsigned a;
        host_read(TERM_DRAM, addr, len);
        for (int i = 0; i < len && i < rd_q.size(); i++) begin
            a = (32'(addr) + 32'(i)) & 32'h3FFF_FFFF;
            check(tag, rd_q[i], ref_mem.exists(a) ? ref_mem[a] : 8'h00);
        end
    endtask

    task automatic fill_rand(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic fill_const(input int n, input logic [7:0] v);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back(v);
    endtask

    task automatic wait_resetb(output int n, output int cr_bad);
        n = 0;
        cr_bad = 0;
        while (n < 100) begin
            @(posedge clk); #1;
            n++;
            if (resetb) break;
            if (bus.host_cmd_ready) cr_bad++;
        end
    endtask

    initial begin
        int n;
        int cr_bad;
        int wr0;
        int bm0;
        int cmd0;

        reset              = 1'b1;
        bus.host_cmd_valid = 1'b0;
        bus.host_cmd_wr    = 1'b0;
        bus.host_term      = '0;
        bus.host_addr      = '0;
        bus.host_len       = '0;
        bus.host_wdata     = '0;
        bus.host_wvalid    = 1'b0;
        bus.host_rready    = 1'b0;
        bus.pll_locked     = 1'b1;
        bus.calib_done     = 1'b0;

        // Reset state and resetb stretch.
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_resetb", resetb, 1'b0);
        check("rst_cmd_ready", bus.host_cmd_ready, 1'b0);
        check("rst_rvalid", bus.host_rvalid, 1'b0);
        check("rst_wready", bus.host_wready, 1'b0);
        check("rst_done", bus.host_done, 1'b0);
        check("rst_mem_cmd_valid", bus.mem_cmd_valid, 1'b0);
        #1 reset = 1'b0;
        wait_resetb(n, cr_bad);
        check("resetb_low_clocks", n, 16);
        check("cmd_ready_while_resetb_low", cr_bad, 0);
        check("cmd_ready_after_resetb", bus.host_cmd_ready, 1'b1);

        // FPGA version register and register-space boundaries.
        host_read(TERM_FPGA, 30'd0, 2);
        check("version_b0", rd_q[0], 8'h30);
        check("version_b1", rd_q[1], 8'h01);
        host_read(TERM_FPGA, 30'd0, 4);
        check("version_len4_b2", rd_q[2], 8'h00);
        check("version_len4_b3", rd_q[3], 8'h00);
        host_read(16'h0007, 30'd0, 2);
        check("unknown_term_b0", rd_q[0], 8'h00);
        check("unknown_term_b1", rd_q[1], 8'h00);
        host_read(TERM_FPGA, 30'd1, 1);
        check("unknown_addr_b0", rd_q[0], 8'h00);
        cmd0 = all_cmds;
        fill_rand(3);
        host_write(TERM_FPGA, 30'd0, 3);
        check("reg_write_no_mem_cmd", all_cmds, cmd0);
        host_read(TERM_FPGA, 30'd0, 1);
        check("version_after_write", rd_q[0], 8'h30);
        send_cmd(1'b0, TERM_FPGA, 30'd0, 32'd0);
        wait_done("len0");

        // DRAM_CTRL status before and after calibration.
        host_read(TERM_DRAM_CTRL, 30'd0, 2);
        check("status_precal_b0", rd_q[0], 8'h01);
        check("status_precal_b1", rd_q[1], 8'h00);
        repeat (1000) @(posedge clk);
        #1 bus.calib_done = 1'b1;
        host_read(TERM_DRAM_CTRL, 30'd0, 2);
        check("status_cal_b0", rd_q[0], 8'h03);
        check("status_cal_b1", rd_q[1], 8'h00);

        // Aligned bulk write then two read-backs.
        fill_rand(516);
        wr0 = wr_cmds;
        bm0 = bad_masks;
        host_write(TERM_DRAM, 30'h123_4560, 516);
        check("bulk_write_cmds", wr_cmds - wr0, 129);
        check("bulk_write_partial_masks", bad_masks - bm0, 0);
        dram_read_check("bulk_read1", 30'h123_4560, 516);
        dram_read_check("bulk_read2", 30'h123_4560, 516);

        // Overlapping regions, read across the seam.
        fill_const(516, 8'hAA);
        host_write(TERM_DRAM, 30'd100, 516);
        fill_const(24, 8'h55);
        host_write(TERM_DRAM, 30'd76, 24);
        dram_read_check("seam_read", 30'd76, 540);
        check("seam_first", rd_q[0], 8'h55);
        check("seam_byte23", rd_q[23], 8'h55);
        check("seam_byte24", rd_q[24], 8'hAA);
        check("seam_last", rd_q[539], 8'hAA);

        // Unaligned short write: one command, word 1, lanes 1..3.
        fill_rand(3);
        wr0 = wr_cmds;
        host_write(TERM_DRAM, 30'd5, 3);
        check("short_write_cmds", wr_cmds - wr0, 1);
        check("short_write_addr", last_addr, 28'd1);
        check("short_write_mask", last_mask, 4'b1110);
        dram_read_check("short_read", 30'd4, 4);

        // Reset in the middle of a DRAM write burst.
        cmd0 = all_cmds;
        fill_rand(8);
        send_cmd(1'b1, TERM_DRAM, 30'h40, 32'd8);
        send_wbytes(2);
        @(negedge clk); #1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_cmd_ready", bus.host_cmd_ready, 1'b0);
        check("abort_mem_cmd_valid", bus.mem_cmd_valid, 1'b0);
        check("abort_wready", bus.host_wready, 1'b0);
        #1 reset = 1'b0;
        wait_resetb(n, cr_bad);
        check("abort_resetb_low_clocks", n, 16);
        repeat (10) @(posedge clk);
        #1;
        check("abort_idle", bus.host_cmd_ready, 1'b1);
        check("abort_no_mem_cmds", all_cmds, cmd0);
        dram_read_check("abort_read", 30'h40, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uxn1330_host_bridge.md
Name: uxn1330_host_bridge

Overview:
- Host-side terminal bridge for the UXN1330 board top level.
- Accepts FX3-style terminal commands: get/set of registers, and byte-stream read/write of DRAM.
- Decodes three terminals: FPGA (version), DRAM_CTRL (PLL/calibration status) and DRAM (byte-addressed bulk memory).
- Sits between the FX3 host interface and the memory-controller user port; also generates the project-level `resetb`.

Parameters:
- VERSION, 16'h0130, value returned by FPGA_version.
- TERM_FPGA, 16'h0001, terminal number of the FPGA terminal.
- TERM_DRAM_CTRL, 16'h0002, terminal number of the DRAM controller status terminal.
- TERM_DRAM, 16'h0003, terminal number of the DRAM memory terminal.
- RESET_CYCLES, 16, clocks that `resetb` is held low after reset.
- DRAM_BYTES, 2**26, DRAM size in bytes (used only when the optional feature is enabled).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- resetb  out  1  project reset, active-low; deasserts RESET_CYCLES clocks after reset drops.
- host_cmd_valid  in  1  command strobe.
- host_cmd_ready  out  1  bridge idle and out of reset.
- host_cmd_wr  in  1  1 = set/write, 0 = get/read.
- host_term  in  16  terminal number.
- host_addr  in  30  register address or DRAM byte address.
- host_len  in  32  transfer length in bytes, must be ≥1.
- host_wdata  in  8  write byte.
- host_wvalid  in  1  write byte valid.
- host_wready  out  1  write byte accepted.
- host_rdata  out  8  read byte.
- host_rvalid  out  1  read byte valid.
- host_rready  in  1  host accepts read byte.
- host_done  out  1  one-cycle pulse when a transfer completes.
- pll_locked  in  1  memory controller PLL lock.
- calib_done  in  1  memory controller calibration done.
- mem_cmd_valid  out  1  memory command strobe.
- mem_cmd_ready  in  1  memory controller accepts command.
- mem_cmd_we  out  1  1 = write, 0 = read.
- mem_cmd_addr  out  28  32-bit word address (byte address [29:2]).
- mem_wdata  out  32  write word; byte lane k = byte address k mod 4.
- mem_wmask  out  4  active-high byte enables.
- mem_rdata  in  32  read word.
- mem_rvalid  in  1  read word valid, one per read command.

Behaviour:
- Reset:
  - All valid, ready and done outputs are 0; state is IDLE.
  - `resetb` is 0; the reset counter clears, then increments each clock.
  - `resetb` goes to 1 when the counter reaches RESET_CYCLES and stays 1 until the next reset.
- Command acceptance:
  - `host_cmd_ready` = `resetb` & (state == IDLE).
  - A command is accepted when `host_cmd_valid` & `host_cmd_ready`.
  - `host_term`, `host_addr` and `host_len` are latched; the byte counter is loaded with `host_len`.
- State machine: IDLE -> REG_RD | REG_WR | MEM_WAIT -> MEM_RD | MEM_WR -> DONE -> IDLE.
  - DONE pulses `host_done` for one cycle.
- Register terminals, little-endian byte stream:
  - FPGA addr 0: VERSION, 2 bytes.
  - DRAM_CTRL addr 0: 16-bit status word; bit0 = `pll_locked`, bit1 = `calib_done`, others 0.
  - Status bits are sampled when each byte is emitted.
  - Bytes beyond the register width, unknown addresses and unknown terminals read as 0x00.
  - All register writes are accepted and discarded (registers are read-only).
- DRAM terminal:
  - MEM_WAIT holds until `calib_done`=1.
  - MEM_WR:
    - Bytes are packed into a word buffer at lane = addr[1:0], setting the matching mask bit.
    - A word is flushed on lane 3 or on the last byte.
    - `host_wready` = 0 while a flush is pending (`mem_cmd_valid` & !`mem_cmd_ready`).
    - Mask bits clear after each flush.
    - Unaligned start or end writes only the enabled lanes.
  - MEM_RD:
    - One outstanding read at a time. The response word is held and bytes are emitted from lane addr[1:0].
    - Each byte is held until `host_rready`. The next word address is issued after lane 3 is consumed.
  - The address increments per byte and wraps modulo 2^30.
- `host_len`=0 goes straight to DONE.
- Reset mid-transfer: abort immediately, drop the partial word, return to IDLE.

Optional Feature:
- Macro DRAM_RANGE_CHECK_EN.
- When defined:
  - Any DRAM byte with address ≥ DRAM_BYTES is not written and reads as 0x00.
  - Out-of-range bytes issue no mem command.
  - Status bit2 is a sticky range error, cleared on reset or when that status byte is read.
- When undefined: no check, status bit2 is 0, addresses wrap at 2^30.

Test Plan:
- Reset for 5 cycles, release -> `resetb` = 0 for exactly 16 clocks; `host_cmd_ready` = 0 until `resetb` = 1.
- Get FPGA addr 0, len 2 -> bytes 0x30, 0x01, then `host_done` pulse.
- Poll DRAM_CTRL status with `calib_done` raised after 1000 clocks -> reads return 0x01 before calibration and 0x03 after (pll_locked=1).
- Write 516 random bytes to aligned address 0x1234560, then read 516 bytes back twice -> all bytes match; exactly 129 write commands issued, each with mask 0xF.
- Write 516×0xAA at addr 100, 24×0x55 at addr 76, read 540 bytes from 76 -> bytes 0–23 = 0x55, bytes 24–539 = 0xAA.
- Write 3 bytes at addr 0x5 -> single command, word addr 1, mask 4'b1110; assert reset mid-burst -> returns to IDLE with no further mem commands.
